// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the MIPS pipeline run-control slice.
//   run_state_t : run-control FSM states; numeric values are the o_state codes
//   STG_*       : pipeline register group indices used to address the
//                 per-stage enable / flush / valid vectors
// ---------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } run_state_t;

    localparam int STG_PC     = 0;
    localparam int STG_IF_ID  = 1;
    localparam int STG_ID_EX  = 2;
    localparam int STG_EX_MEM = 3;
    localparam int STG_MEM_WB = 4;

endpackage

// File: rtl/pipeline_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_run_ctrl_if
// Groups the debug/hazard request inputs and the stage-control outputs of
// pipeline_run_ctrl.
//   master : requester side (debug unit, hazard unit, testbench)
//   slave  : pipeline_run_ctrl side
// Signals:
//   i_run, i_step, i_halt_W, i_stall_HD, i_flush_D  requests into the block
//   o_stage_en, o_stage_flush, o_valid              per-stage vectors
//   o_state, o_cycles, o_done                       run-control status
// ---------------------------------------------------------------------------
interface pipeline_run_ctrl_if #(
    parameter int STAGES = 5,
    parameter int CNT_SZ = 32
);
    logic              i_run;
    logic              i_step;
    logic              i_halt_W;
    logic              i_stall_HD;
    logic              i_flush_D;
    logic [STAGES-1:0] o_stage_en;
    logic [STAGES-1:0] o_stage_flush;
    logic [STAGES-1:0] o_valid;
    logic [1:0]        o_state;
    logic [CNT_SZ-1:0] o_cycles;
    logic              o_done;

    modport master (
        output i_run, i_step, i_halt_W, i_stall_HD, i_flush_D,
        input  o_stage_en, o_stage_flush, o_valid, o_state, o_cycles, o_done
    );

    modport slave (
        input  i_run, i_step, i_halt_W, i_stall_HD, i_flush_D,
        output o_stage_en, o_stage_flush, o_valid, o_state, o_cycles, o_done
    );
endinterface

// File: rtl/pipeline_run_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   reset : synchronous active-high clear
//   inc   : count one when high
//   count : current value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: clocked state always uses non-blocking assignment so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_run_ctrl
// Run-control and stage-enable sequencer for the N-stage MIPS pipeline.
// Produces per-stage enable/flush vectors, merges hazard stall and decode
// flush requests, tracks per-stage valid bits and counts advance cycles.
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   bus     : pipeline_run_ctrl_if.slave (requests in, stage control out)
// Build option:
//   PIPELINE_RUN_CTRL_STEP_EN  defined   -> i_step single-steps from IDLE
//                              undefined -> i_step ignored, STEP unreachable
// ---------------------------------------------------------------------------
module pipeline_run_ctrl
    import pipeline_pkg::*;
#(
    parameter int STAGES = 5,   // minimum 3 (PC, IF/ID, ID/EX are addressed)
    parameter int CNT_SZ = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    pipeline_run_ctrl_if.slave   bus
);

    run_state_t        state;
    run_state_t        state_nxt;
    logic              adv;
    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] stage_flush;
    logic [STAGES-1:0] valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        stage_en    = '0;
        stage_flush = '0;

        case (state)
            ST_IDLE: begin
                if (bus.i_run) begin
                    state_nxt = ST_RUN;
                end
`ifdef PIPELINE_RUN_CTRL_STEP_EN
                else if (bus.i_step) begin
                    state_nxt = ST_STEP;
                end
`endif
            end
            ST_RUN: begin
                if (bus.i_halt_W) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_STEP: begin
                state_nxt = bus.i_halt_W ? ST_HALTED : ST_IDLE;
            end
            default: begin
                state_nxt = ST_HALTED;
            end
        endcase

        // The halt sits in MEM/WB and must not be shifted out, so a halt
        // cycle never advances.
        adv = ((state == ST_RUN) || (state == ST_STEP)) && !bus.i_halt_W;

        // A stall freezes PC and IF/ID; later stages keep draining.
        for (int k = 0; k < STAGES; k++) begin
            stage_en[k] = adv && !(bus.i_stall_HD && (k <= STG_IF_ID));
        end

        // Stall bubbles ID/EX and takes priority over the decode flush,
        // because the instruction held in IF/ID is still needed.
        stage_flush[STG_ID_EX] = adv && bus.i_stall_HD;
        stage_flush[STG_IF_ID] = adv && bus.i_flush_D && !bus.i_stall_HD;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid <= '0;
        end else if (adv) begin
            valid[STG_PC] <= 1'b1;
            for (int k = 1; k < STAGES; k++) begin
                if (stage_flush[k]) begin
                    valid[k] <= 1'b0;
                end else if (stage_en[k]) begin
                    valid[k] <= valid[k-1];
                end
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_SZ)
    ) u_cycles (
        .clk   (i_clk),
        .reset (i_reset),
        .inc   (adv),
        .count (bus.o_cycles)
    );

    assign bus.o_stage_en    = stage_en;
    assign bus.o_stage_flush = stage_flush;
    assign bus.o_valid       = valid;
    assign bus.o_state       = state;
    assign bus.o_done        = (state == ST_HALTED);

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_run_ctrl
// Self-checking bench for pipeline_run_ctrl. A behavioural model (mode
// number, valid array, cycle total) predicts every output; a second DUT
// with a 3-bit counter covers saturation.
// ---------------------------------------------------------------------------
module tb_pipeline_run_ctrl;

`ifdef PIPELINE_RUN_CTRL_STEP_EN
    localparam bit STEP_ON = 1'b1;
`else
    localparam bit STEP_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    pipeline_run_ctrl_if #(.STAGES(5), .CNT_SZ(32)) bus  ();
    pipeline_run_ctrl_if #(.STAGES(5), .CNT_SZ(3))  sbus ();

    pipeline_run_ctrl #(.STAGES(5), .CNT_SZ(32)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    pipeline_run_ctrl #(.STAGES(5), .CNT_SZ(3)) dut_sat (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_mode: 0 idle, 1 running, 2 single step, 3 halted
    int          m_mode;
    bit          m_valid [5];
    logic [31:0] m_cycles;

    function automatic bit m_adv();
        return (m_mode == 1 || m_mode == 2) && !bus.i_halt_W;
    endfunction

    function automatic logic [4:0] m_en();
        logic [4:0] e;
        for (int k = 0; k < 5; k++) e[k] = m_adv() && !(bus.i_stall_HD && k < 2);
        return e;
    endfunction

    function automatic logic [4:0] m_fl();
        logic [4:0] f = '0;
        if (m_adv() && bus.i_stall_HD)     f[2] = 1'b1;
        else if (m_adv() && bus.i_flush_D) f[1] = 1'b1;
        return f;
    endfunction

    function automatic logic [4:0] m_vld();
        logic [4:0] v;
        for (int k = 0; k < 5; k++) v[k] = m_valid[k];
        return v;
    endfunction

    function automatic logic [49:0] m_expect();
        return {m_en(), m_fl(), m_vld(), 2'(m_mode), m_cycles, (m_mode == 3)};
    endfunction

    function automatic logic [49:0] dut_obs();
        return {bus.o_stage_en, bus.o_stage_flush, bus.o_valid, bus.o_state,
                bus.o_cycles, bus.o_done};
    endfunction

    // Called at each rising edge with the inputs of the cycle just ending.
    task automatic model_clock();
        bit         nv [5];
        logic [4:0] e;
        logic [4:0] f;
        if (rst) begin
            m_mode = 0;
            foreach (m_valid[k]) m_valid[k] = 1'b0;
            m_cycles = '0;
            return;
        end
        e = m_en();
        f = m_fl();
        if (m_adv()) begin
            nv[0] = 1'b1;
            for (int k = 1; k < 5; k++)
                nv[k] = f[k] ? 1'b0 : (e[k] ? m_valid[k-1] : m_valid[k]);
            m_valid = nv;
            if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
        end
        case (m_mode)
            0: if (bus.i_run) m_mode = 1;
               else if (STEP_ON && bus.i_step) m_mode = 2;
            1: if (bus.i_halt_W) m_mode = 3;
            2: m_mode = bus.i_halt_W ? 3 : 0;
            default: m_mode = 3;
        endcase
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic drive(input bit run, input bit step, input bit halt,
                         input bit stall, input bit flush);
        bus.i_run      = run;
        bus.i_step     = step;
        bus.i_halt_W   = halt;
        bus.i_stall_HD = stall;
        bus.i_flush_D  = flush;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        advance();
        advance();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 0, 1, 1);
        advance();
        advance();
        rst = 1'b0;
        drive(0, 0, 0, 1, 1);
        @(negedge clk);
        tests++;
        if ({bus.o_state, bus.o_valid, bus.o_cycles, bus.o_done,
             bus.o_stage_en, bus.o_stage_flush} !== {2'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0}) begin
            fails++;
            $display("FAIL reset_state got st=%0d v=%b c=%0d d=%b en=%b fl=%b exp all zero",
                     bus.o_state, bus.o_valid, bus.o_cycles, bus.o_done,
                     bus.o_stage_en, bus.o_stage_flush);
        end
        advance();
    endtask

    task automatic test_run();
        do_reset();
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if (bus.o_stage_en !== 5'b00000) begin
            fails++;
            $display("FAIL run_idle_en got=%b exp=00000", bus.o_stage_en);
        end
        advance();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            tests++;
            if (bus.o_state !== 2'd1 || bus.o_stage_en !== 5'b11111) begin
                fails++;
                $display("FAIL run_cycle%0d got st=%0d en=%b exp st=1 en=11111",
                         i, bus.o_state, bus.o_stage_en);
            end
            advance();
        end
        @(negedge clk);
        tests++;
        if (bus.o_cycles !== 32'd7 || bus.o_valid !== 5'b11111) begin
            fails++;
            $display("FAIL run_after7 got c=%0d v=%b exp c=7 v=11111",
                     bus.o_cycles, bus.o_valid);
        end
    endtask

    // Continues from RUN with a full pipe left by test_run.
    task automatic test_stall_flush();
        drive(0, 0, 0, 1, 0);
        @(negedge clk);
        tests++;
        if (bus.o_stage_en !== 5'b11100 || bus.o_stage_flush !== 5'b00100) begin
            fails++;
            $display("FAIL stall got en=%b fl=%b exp en=11100 fl=00100",
                     bus.o_stage_en, bus.o_stage_flush);
        end
        advance();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if (bus.o_valid[2] !== 1'b0) begin
            fails++;
            $display("FAIL stall_bubble got v=%b exp v[2]=0", bus.o_valid);
        end
        advance();
        drive(0, 0, 0, 1, 1);
        @(negedge clk);
        tests++;
        if (bus.o_stage_flush !== 5'b00100) begin
            fails++;
            $display("FAIL stall_beats_flush got fl=%b exp=00100", bus.o_stage_flush);
        end
        advance();
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        tests++;
        if (bus.o_stage_flush !== 5'b00010 || bus.o_stage_en !== 5'b11111) begin
            fails++;
            $display("FAIL flush_only got fl=%b en=%b exp fl=00010 en=11111",
                     bus.o_stage_flush, bus.o_stage_en);
        end
        advance();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if (bus.o_valid[1] !== 1'b0) begin
            fails++;
            $display("FAIL flush_clears_ifid got v=%b exp v[1]=0", bus.o_valid);
        end
    endtask

    task automatic test_step();
        int pulses = 0;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 3; c++) begin
                drive(0, c == 0, 0, 0, 0);
                @(negedge clk);
                if (bus.o_stage_en !== 5'b00000) pulses++;
                tests++;
                if (dut_obs() !== m_expect()) begin
                    fails++;
                    $display("FAIL step_p%0d_c%0d got=%h exp=%h", p, c, dut_obs(), m_expect());
                end
                advance();
            end
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if (pulses != (STEP_ON ? 3 : 0) || bus.o_cycles !== (STEP_ON ? 32'd3 : 32'd0)
            || bus.o_state !== 2'd0) begin
            fails++;
            $display("FAIL step_total got pulses=%0d c=%0d st=%0d exp pulses=%0d c=%0d st=0",
                     pulses, bus.o_cycles, bus.o_state, STEP_ON ? 3 : 0, STEP_ON ? 3 : 0);
        end
    endtask

    task automatic test_halt();
        logic [31:0] frozen;
        do_reset();
        drive(1, 0, 0, 0, 0);
        advance();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) advance();
        drive(0, 0, 1, 0, 0);
        @(negedge clk);
        frozen = m_cycles;
        tests++;
        if (bus.o_stage_en !== 5'b00000 || bus.o_cycles !== 32'd10) begin
            fails++;
            $display("FAIL halt_cycle got en=%b c=%0d exp en=00000 c=10",
                     bus.o_stage_en, bus.o_cycles);
        end
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, i < 2, 1, 1);
            @(negedge clk);
            tests++;
            if (bus.o_done !== 1'b1 || bus.o_state !== 2'd3 || bus.o_stage_en !== 5'b00000
                || bus.o_cycles !== frozen) begin
                fails++;
                $display("FAIL halted_%0d got d=%b st=%0d en=%b c=%0d exp d=1 st=3 en=00000 c=%0d",
                         i, bus.o_done, bus.o_state, bus.o_stage_en, bus.o_cycles, frozen);
            end
            advance();
        end
        do_reset();
        @(negedge clk);
        tests++;
        if (bus.o_state !== 2'd0 || bus.o_cycles !== 32'd0 || bus.o_done !== 1'b0) begin
            fails++;
            $display("FAIL halt_reset got st=%0d c=%0d d=%b exp st=0 c=0 d=0",
                     bus.o_state, bus.o_cycles, bus.o_done);
        end
    endtask

    task automatic test_run_beats_step();
        do_reset();
        drive(1, 1, 0, 0, 0);
        advance();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if (bus.o_state !== 2'd1) begin
            fails++;
            $display("FAIL run_beats_step got st=%0d exp=1", bus.o_state);
        end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0);
            @(negedge clk);
            tests++;
            if (dut_obs() !== m_expect()) begin
                fails++;
                $display("FAIL random_%0d got=%h exp=%h", i, dut_obs(), m_expect());
            end
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        sbus.i_run = 1'b1;
        advance();
        sbus.i_run = 1'b0;
        for (int i = 0; i <= 11; i++) begin
            @(negedge clk);
            tests++;
            if (sbus.o_cycles !== 3'((i > 7) ? 7 : i)) begin
                fails++;
                $display("FAIL sat_after%0d got=%0d exp=%0d", i, sbus.o_cycles, (i > 7) ? 7 : i);
            end
            advance();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        m_mode = 0;
        m_cycles = '0;
        foreach (m_valid[k]) m_valid[k] = 1'b0;
        drive(0, 0, 0, 0, 0);
        sbus.i_run      = 1'b0;
        sbus.i_step     = 1'b0;
        sbus.i_halt_W   = 1'b0;
        sbus.i_stall_HD = 1'b0;
        sbus.i_flush_D  = 1'b0;
        #1;
        test_reset();
        test_run();
        test_stall_flush();
        test_step();
        test_halt();
        test_run_beats_step();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
